// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Constants and helpers shared by the VGA pan control and display stages.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE      = 640;
    localparam int V_ACTIVE      = 480;
    localparam int OFF_W         = 12;
    localparam int X_OFF_MAX_DEF = 320;
    localparam int Y_OFF_MAX_DEF = 240;

    typedef struct packed {
        logic ret;
        logic left;
        logic right;
        logic up;
        logic down;
    } pan_sw_t;

    // One axis step: a wider sum keeps cur+step from wrapping before the clamp.
    function automatic logic [OFF_W-1:0] pan_step(
        input logic [OFF_W-1:0] cur,
        input logic             inc,
        input logic             dec,
        input logic [OFF_W-1:0] step,
        input logic [OFF_W-1:0] max
    );
        logic [OFF_W:0] sum;
        sum      = {1'b0, cur} + {1'b0, step};
        pan_step = cur;
        if (inc && !dec) begin
            pan_step = (sum > {1'b0, max}) ? max : sum[OFF_W-1:0];
        end else if (dec && !inc) begin
            pan_step = (cur < step) ? '0 : (cur - step);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : vga_btn_debounce
// Purpose  : Two-flop synchronizer followed by a stable-count switch debouncer.
// Revision : 1.0
// ============================================================================
module vga_btn_debounce #(
    parameter int DEB_CYC = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic level
);

    localparam int              CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= sw;
            sync_b <= sync_a;
            // Any cycle agreeing with the stable state restarts the qualification window.
            if (sync_b != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= ~stable;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = stable;

endmodule
`default_nettype wire

// File: rtl/vga_pan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_pan_ctrl
// Purpose  : Debounced front-panel pan control; offsets update once per frame at vsync start.
// Revision : 1.0
// ============================================================================
module vga_pan_ctrl
    import vga_pkg::*;
#(
    parameter int DEB_CYC   = 250000,
    parameter int STEP      = 4,
    parameter int X_OFF_MAX = X_OFF_MAX_DEF,
    parameter int Y_OFF_MAX = Y_OFF_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs,
    input  logic             sw_left,
    input  logic             sw_right,
    input  logic             sw_up,
    input  logic             sw_down,
    input  logic             sw_return,
    output logic [OFF_W-1:0] x_off,
    output logic [OFF_W-1:0] y_off,
    output logic             frame_tick,
    output logic             moving
);

    localparam logic [OFF_W-1:0] STEP_V = OFF_W'(STEP);
    localparam logic [OFF_W-1:0] XMAX_V = OFF_W'(X_OFF_MAX);
    localparam logic [OFF_W-1:0] YMAX_V = OFF_W'(Y_OFF_MAX);

    pan_sw_t          raw;
    pan_sw_t          db;
    logic [4:0]       raw_bits;
    logic [4:0]       db_bits;
    logic             vs_d;
    logic             sync_start;
    logic [OFF_W-1:0] x_nxt;
    logic [OFF_W-1:0] y_nxt;

    assign raw      = '{ret: sw_return, left: sw_left, right: sw_right, up: sw_up, down: sw_down};
    assign raw_bits = raw;
    assign db       = pan_sw_t'(db_bits);

    for (genvar i = 0; i < 5; i++) begin : g_deb
        vga_btn_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .sw    (raw_bits[i]),
            .level (db_bits[i])
        );
    end

    assign sync_start = vs_d & ~vs;

    // Return overrides both axes for the frame it is seen in.
    always_comb begin
        x_nxt = pan_step(x_off, db.right, db.left, STEP_V, XMAX_V);
        y_nxt = pan_step(y_off, db.down,  db.up,   STEP_V, YMAX_V);
        if (db.ret) begin
            x_nxt = '0;
            y_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d       <= 1'b1;
            frame_tick <= 1'b0;
            x_off      <= '0;
            y_off      <= '0;
        end else begin
            vs_d       <= vs;
            frame_tick <= sync_start;
            if (sync_start) begin
                x_off <= x_nxt;
                y_off <= y_nxt;
            end
        end
    end

    assign moving = db.left | db.right | db.up | db.down;

endmodule
`default_nettype wire

// File: tb/tb_vga_pan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_pan_ctrl
// Purpose  : Directed scoreboard bench for vga_pan_ctrl (DEB_CYC=4, STEP=4, Y_OFF_MAX=62).
// Revision : 1.0
// ============================================================================
module tb_vga_pan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vs;
    logic        sw_left, sw_right, sw_up, sw_down, sw_return;
    logic [11:0] x_off, y_off;
    logic        frame_tick, moving;

    int          tests = 0;
    int          fails = 0;
    logic [23:0] sb[$];
    logic [23:0] exp_xy;

    always #20 clk = ~clk;

    vga_pan_ctrl #(
        .DEB_CYC   (4),
        .STEP      (4),
        .X_OFF_MAX (320),
        .Y_OFF_MAX (62)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vs         (vs),
        .sw_left    (sw_left),
        .sw_right   (sw_right),
        .sw_up      (sw_up),
        .sw_down    (sw_down),
        .sw_return  (sw_return),
        .x_off      (x_off),
        .y_off      (y_off),
        .frame_tick (frame_tick),
        .moving     (moving)
    );

    // Every tick must match the oldest expected offset pair.
    always @(negedge clk) begin
        if (rst === 1'b1 && frame_tick === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_tick: got tick with x=%0d y=%0d, expected no tick", x_off, y_off);
            end
            if (sb.size() != 0) begin
                exp_xy = sb.pop_front();
                tests++;
                assert ({x_off, y_off} === exp_xy) else begin
                    fails++;
                    $error("FAIL tick_offsets: got x=%0d y=%0d, expected x=%0d y=%0d",
                           x_off, y_off, exp_xy[23:12], exp_xy[11:0]);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    // One short frame: vs low for three cycles, then high for four.
    task automatic frame(input int ex, input int ey);
        logic [11:0] xe, ye;
        xe = ex[11:0];
        ye = ey[11:0];
        sb.push_back({xe, ye});
        @(negedge clk) vs = 1'b0;
        @(negedge clk);
        #1 check("tick_latency", sb.size(), 0);
        repeat (2) @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; vs = 1'b1;
        sw_left = 1'b0; sw_right = 1'b0; sw_up = 1'b0; sw_down = 1'b0; sw_return = 1'b0;

        repeat (3) begin
            @(negedge clk) vs = 1'b0;
            @(negedge clk) vs = 1'b1;
            check("rst_x", x_off, 0);
            check("rst_y", y_off, 0);
            check("rst_tick", frame_tick, 0);
        end
        check("rst_moving", moving, 0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        frame(0, 0);

        // Three-cycle glitch stays below the debounce window.
        sw_right = 1'b1;
        repeat (3) @(negedge clk);
        sw_right = 1'b0;
        settle();
        check("glitch_moving", moving, 0);
        repeat (3) frame(0, 0);

        sw_right = 1'b1;
        settle();
        check("held_moving", moving, 1);
        for (int i = 1; i <= 79; i++) frame(4 * i, 0);
        frame(320, 0);
        frame(320, 0);
        sw_right = 1'b0;
        settle();
        check("release_moving", moving, 0);

        sw_down = 1'b1;
        settle();
        for (int i = 1; i <= 15; i++) frame(320, 4 * i);
        frame(320, 62);
        frame(320, 62);
        sw_down = 1'b0;
        sw_up   = 1'b1;
        settle();
        for (int i = 1; i <= 15; i++) frame(320, 62 - 4 * i);
        frame(320, 0);
        frame(320, 0);
        sw_up   = 1'b0;

        sw_left = 1'b1;
        settle();
        for (int i = 1; i <= 78; i++) frame(320 - 4 * i, 0);
        sw_right = 1'b1;
        sw_down  = 1'b1;
        settle();
        frame(8, 4);
        sw_right = 1'b0;
        sw_down  = 1'b0;
        settle();
        check("left_only_moving", moving, 1);
        frame(4, 4);
        frame(0, 4);
        frame(0, 4);
        sw_left = 1'b0;

        sw_right = 1'b1;
        sw_down  = 1'b1;
        settle();
        for (int i = 1; i <= 14; i++) frame(4 * i, 4 + 4 * i);
        sw_down = 1'b0;
        settle();
        for (int i = 15; i <= 25; i++) frame(4 * i, 60);
        sw_return = 1'b1;
        settle();
        frame(0, 0);
        sw_return = 1'b0;
        settle();
        frame(4, 0);
        for (int i = 2; i <= 10; i++) frame(4 * i, 0);
        check("pre_reset_x", x_off, 40);

        // Asynchronous reset in the middle of a frame, switch still held.
        @(negedge clk);
        #5 rst = 1'b0;
        #1;
        check("async_rst_x", x_off, 0);
        check("async_rst_y", y_off, 0);
        check("async_rst_moving", moving, 0);
        @(negedge clk) rst = 1'b1;
        settle();
        frame(4, 0);

        // vs already low at release gives exactly one tick.
        @(negedge clk) rst = 1'b0;
        vs = 1'b0;
        sb.push_back(24'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        #1 check("release_low_tick", sb.size(), 0);
        repeat (4) @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vga_pan_ctrl.md
# vga_pan_ctrl

Front-panel control stage upstream of the VGA display block, clocked by the 25 MHz pixel clock. It debounces the five direction/return switches and maintains the picture pan offsets (x_off, y_off) that the display stage adds to x_cnt/y_cnt when it forms the picture address. Offsets change only once per frame, at the start of vertical sync, so a frame is never drawn with two different offsets (no tearing).

## Interface
- DEB_CYC, 250000: consecutive stable cycles required to accept a switch change (10 ms at 25 MHz).
- STEP, 4: pixels moved per frame while a direction switch is held.
- X_OFF_MAX, 320: upper clamp for x_off.
- Y_OFF_MAX, 240: upper clamp for y_off.
- Clk  in  1  pixel clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- vs  in  1  vertical sync from the timing generator, active-low.
- sw_left, sw_right, sw_up, sw_down  in  1 each  raw switch levels, 1 = pressed.
- sw_return  in  1  raw level, 1 = request pan reset.
- x_off  out  12  horizontal pan offset, 0..X_OFF_MAX.
- y_off  out  12  vertical pan offset, 0..Y_OFF_MAX.
- frame_tick  out  1  one-cycle pulse on each applied frame update.
- moving  out  1  1 while any debounced direction switch is active.

## Operation
- Each switch passes through a 2-FF synchronizer and then a debouncer. The debouncer holds a stable state and a counter. While the synchronized level differs from the stable state, the counter increments. When it reaches DEB_CYC-1 the stable state flips and the counter clears. Any cycle where the level equals the stable state clears the counter.
- Frame tick: vs is registered to vs_d. A start-of-sync condition is vs_d=1 and vs=0. frame_tick is registered from this condition, so it is high for exactly one cycle per frame.
- On the frame_tick cycle, updates are applied with this priority:
  1. Debounced return: x_off and y_off are set to 0, and direction switches are ignored for that frame.
  2. Otherwise, horizontal: right only gives x_off = min(x_off+STEP, X_OFF_MAX). Left only gives x_off = (x_off < STEP) ? 0 : x_off-STEP. Left and right together, or neither, leave x_off unchanged.
  3. Otherwise, vertical: down only increases y_off and up only decreases it, with the same clamp rules against Y_OFF_MAX and 0. Up and down together leave y_off unchanged.
- Horizontal and vertical updates are independent, so diagonal panning is allowed.
- Arithmetic uses a 13-bit intermediate sum, so x_off+STEP cannot wrap before the clamp.
- moving = OR of the four debounced direction states. It is combinational from registers.

## Timing
- Reset values: x_off=0, y_off=0, frame_tick=0, moving=0, all debounced states 0, all counters 0, vs_d=1.
- Switch-to-debounced latency is 2 + DEB_CYC cycles. Glitches shorter than DEB_CYC cycles produce no change.
- A held switch moves the offset by exactly STEP per frame, starting with the first frame_tick after the debounced state goes high.
- vs falling at cycle n (first cycle vs=0) gives frame_tick=1 and new offsets visible at cycle n+1. Both return to steady state at n+2.
- vs held low does not retrigger. Only a fresh 1→0 transition produces a tick.
- A reset assertion mid-frame or mid-debounce clears everything immediately. After release, the first tick requires a full vs falling edge. The release-cycle value vs_d=1 means a vs already low at release produces one tick on the first clock.
- At a clamp boundary with the switch held, the offset stays at the boundary. frame_tick still pulses.

## Structure
- Shared package vga_pkg: H_ACTIVE=640, V_ACTIVE=480, OFF_W=12, and the default X_OFF_MAX/Y_OFF_MAX. The display stage uses the same constants.
- Sub-module vga_btn_debounce (synchronizer plus debouncer, parameter DEB_CYC), instantiated five times. Frame-edge detect, update logic and clamps stay in the top level.

## Test plan
Benches use DEB_CYC=4 and STEP=4.
- Reset held with vs toggling -> x_off=y_off=0, frame_tick=0. After release, first vs fall -> frame_tick at n+1, offsets remain 0.
- sw_right pulse of 3 cycles -> no debounced change, x_off stays 0 over 3 frames. sw_right held across 3 frames -> x_off = 4, 8, 12 at successive ticks.
- x_off=316, right held for 2 frames -> 320, 320. y_off=2, up held -> 0.
- Left and right held together with down held, from x=8,y=0 -> x stays 8, y becomes 4.
- Offsets 100/60 with return and right held -> next tick gives 0/0. After return is released and right is still held, the following tick gives x=4.
- Reset asserted mid-frame while x_off=40 -> x_off=0 asynchronously, no frame_tick until the next vs 1→0 transition.
